md_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage of the pipelined CPU. It consumes the ALU operand pair produced by operand selection (`alu_a`, `alu_b`) and executes mult/multu/div/divu iteratively, one bit per cycle. It holds the architectural HI/LO registers and raises a stall request to the pipeline control while an operation is in flight.

---
 rtl/md_unit_if.sv | 22 ++
 rtl/md_unit.sv | 143 ++++++++++++++
 tb/tb_md_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - EX-stage request and HI/LO result bundle of the multiply/divide unit.
interface md_unit_if;
  logic        md_start_ex;
  logic [2:0]  md_op_ex;
  logic        md_cancel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        md_busy;
  logic        md_done;

  modport master (
    output md_start_ex, md_op_ex, md_cancel, alu_a, alu_b,
    input  hi_o, lo_o, md_busy, md_done
  );

  modport slave (
    input  md_start_ex, md_op_ex, md_cancel, alu_a, alu_b,
    output hi_o, lo_o, md_busy, md_done
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative mult/multu/div/divu unit, one bit per cycle, owning HI/LO.
module md_unit (
  input  logic        clk,
  input  logic        rst,
  md_unit_if.slave    md
);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic [31:0] r_orig_a;
  logic        r_is_div;
  logic        r_div0;
  logic        r_neg_p;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_signed = (md.md_op_ex == OP_MULT) || (md.md_op_ex == OP_DIV);
  assign w_sa     = w_signed & md.alu_a[31];
  assign w_sb     = w_signed & md.alu_b[31];
  assign w_a_mag  = w_sa ? (~md.alu_a + 32'd1) : md.alu_a;
  assign w_b_mag  = w_sb ? (~md.alu_b + 32'd1) : md.alu_b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Divide: acc = {partial remainder, dividend/quotient}, restoring compare against divisor.
  assign w_rem_sh   = r_acc[63:31];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_diff[32] ? {r_acc[62:0], 1'b0}
                                 : {w_diff[31:0], r_acc[30:0], 1'b1};

  assign w_prod = r_neg_p ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_neg_p ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 6'd0;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_orig_a <= 32'd0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (md.md_cancel) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (md.md_start_ex) begin
              case (md.md_op_ex)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  r_is_div <= (md.md_op_ex == OP_DIV) || (md.md_op_ex == OP_DIVU);
                  r_div0   <= (md.md_op_ex == OP_DIV || md.md_op_ex == OP_DIVU) &&
                              (md.alu_b == 32'd0);
                  r_orig_a <= md.alu_a;
                  r_neg_p  <= w_sa ^ w_sb;
                  r_neg_r  <= w_sa;
                  if (md.md_op_ex == OP_DIV || md.md_op_ex == OP_DIVU) begin
                    r_opnd <= w_b_mag;
                    r_acc  <= {32'd0, w_a_mag};
                  end else begin
                    r_opnd <= w_a_mag;
                    r_acc  <= {32'd0, w_b_mag};
                  end
                  r_cnt   <= 6'd0;
                  r_busy  <= 1'b1;
                  r_state <= CALC;
                end
                OP_MTHI: r_hi <= md.alu_a;
                OP_MTLO: r_lo <= md.alu_a;
                default: ;
              endcase
            end
          end
          CALC: begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) r_state <= FIX;
          end
          FIX: begin
            if (!r_is_div) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end else if (r_div0) begin
              r_hi <= r_orig_a;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign md.hi_o    = r_hi;
  assign md.lo_o    = r_lo;
  assign md.md_busy = r_busy;
  assign md.md_done = r_done;
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed vector bench for md_unit with cancel/reset corner sequences.
module tb_md_unit;
  logic clk;
  logic rst;
  md_unit_if u_if ();

  md_unit u_dut (.clk(clk), .rst(rst), .md(u_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [10];
  int   n_cmp;
  int   n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cn);
    u_if.md_start_ex = st;
    u_if.md_op_ex    = op;
    u_if.alu_a       = a;
    u_if.alu_b       = b;
    u_if.md_cancel   = cn;
  endtask

  // Leaves the caller at the negedge of the md_done cycle so the next start is back-to-back.
  task automatic run_op(input int idx);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = -1;
    drive(1'b1, vecs[idx].op, vecs[idx].a, vecs[idx].b, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      if (u_if.md_busy) busy_cnt++;
      if (u_if.md_done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d busy_cycles", idx), 64'(busy_cnt), 64'd33);
    check($sformatf("v%0d done_cycle", idx), 64'(done_at), 64'd34);
    check($sformatf("v%0d hi", idx), {32'd0, u_if.hi_o}, {32'd0, vecs[idx].hi});
    check($sformatf("v%0d lo", idx), {32'd0, u_if.lo_o}, {32'd0, vecs[idx].lo});
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    drive(1'b1, 3'b101, h, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b110, l, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      if (u_if.md_done || u_if.md_busy) seen = 1'b1;
      @(negedge clk);
    end
    check(name, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{3'b100, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[5] = '{3'b011, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{3'b100, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[7] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{3'b011, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
    vecs[9] = '{3'b010, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    rst = 1'b1;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset hi", {32'd0, u_if.hi_o}, 64'd0);
    check("reset lo", {32'd0, u_if.lo_o}, 64'd0);
    check("reset busy", {63'd0, u_if.md_busy}, 64'd0);
    check("reset done", {63'd0, u_if.md_done}, 64'd0);

    drive(1'b1, 3'b101, 32'h1234_5678, 32'd0, 1'b0);
    @(negedge clk);
    check("mthi hi", {32'd0, u_if.hi_o}, 64'h1234_5678);
    check("mthi busy", {63'd0, u_if.md_busy}, 64'd0);
    drive(1'b1, 3'b110, 32'h9ABC_DEF0, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("mtlo lo", {32'd0, u_if.lo_o}, 64'h9ABC_DEF0);
    check("mtlo hi kept", {32'd0, u_if.hi_o}, 64'h1234_5678);
    check("mtlo busy", {63'd0, u_if.md_busy}, 64'd0);

    for (int i = 0; i < 10; i++) run_op(i);
    @(negedge clk);
    check("done one-cycle pulse", {63'd0, u_if.md_done}, 64'd0);

    set_hilo(32'h11, 32'h22);
    drive(1'b1, 3'b001, 32'd5, 32'd6, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    check("cancel busy before", {63'd0, u_if.md_busy}, 64'd1);
    u_if.md_cancel = 1'b1;
    @(negedge clk);
    u_if.md_cancel = 1'b0;
    check("cancel busy low", {63'd0, u_if.md_busy}, 64'd0);
    watch_no_done("cancel no done", 40);
    check("cancel hi kept", {32'd0, u_if.hi_o}, 64'h11);
    check("cancel lo kept", {32'd0, u_if.lo_o}, 64'h22);

    set_hilo(32'h11, 32'h22);
    drive(1'b1, 3'b011, 32'd50, 32'd3, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset-mid busy low", {63'd0, u_if.md_busy}, 64'd0);
    watch_no_done("reset-mid no done", 40);
    check("reset-mid hi", {32'd0, u_if.hi_o}, 64'd0);
    check("reset-mid lo", {32'd0, u_if.lo_o}, 64'd0);

    drive(1'b1, 3'b001, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'b101, 32'hDEAD_BEEF, 32'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    watch_no_done("cancel+start no busy", 40);
    check("cancel+mthi hi", {32'd0, u_if.hi_o}, 64'd0);
    check("cancel+start lo", {32'd0, u_if.lo_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
